// File: rtl/uart_rx_frame.sv
// Oversampling UART frame receiver: start bit, DATA_WIDTH data bits (LSB first),
// optional parity bit and one stop bit, each bit decided by a 3-sample majority vote.
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err,
    output logic [2:0]            fsm_state
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state, state_n;
    logic [5:0]            edge_cnt, edge_cnt_n;
    logic [BCW-1:0]        bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic [1:0]            samp, samp_n;
    logic [5:0]            cfg_p, cfg_p_n;
    logic                  cfg_par_en, cfg_par_en_n;
    logic                  cfg_par_typ, cfg_par_typ_n;
    logic                  par_bad, par_bad_n;
    logic                  stp_bad, stp_bad_n;
    logic [DATA_WIDTH-1:0] p_data_n;
    logic                  data_valid_n, par_err_n, stp_err_n;

    // Sample points sit around the bit centre of the frame's latched ratio.
    logic [5:0] half;
    logic       at_s0, at_s1, at_dec, at_end;
    logic       voted;

    assign half   = {1'b0, cfg_p[5:1]};
    assign at_s0  = (edge_cnt == half - 6'd2);
    assign at_s1  = (edge_cnt == half - 6'd1);
    assign at_dec = (edge_cnt == half);
    assign at_end = (edge_cnt == cfg_p - 6'd1);
    assign voted  = (samp[0] & samp[1]) | (samp[0] & RX_IN) | (samp[1] & RX_IN);

    assign fsm_state = state;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= IDLE;
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            samp        <= '0;
            cfg_p       <= 6'd8;
            cfg_par_en  <= 1'b0;
            cfg_par_typ <= 1'b0;
            par_bad     <= 1'b0;
            stp_bad     <= 1'b0;
            P_DATA      <= '0;
            Data_Valid  <= 1'b0;
            Par_Err     <= 1'b0;
            Stp_Err     <= 1'b0;
        end else begin
            state       <= state_n;
            edge_cnt    <= edge_cnt_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            samp        <= samp_n;
            cfg_p       <= cfg_p_n;
            cfg_par_en  <= cfg_par_en_n;
            cfg_par_typ <= cfg_par_typ_n;
            par_bad     <= par_bad_n;
            stp_bad     <= stp_bad_n;
            P_DATA      <= p_data_n;
            Data_Valid  <= data_valid_n;
            Par_Err     <= par_err_n;
            Stp_Err     <= stp_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        edge_cnt_n    = at_end ? 6'd0 : edge_cnt + 6'd1;
        bit_cnt_n     = bit_cnt;
        shift_n       = shift;
        samp_n        = samp;
        cfg_p_n       = cfg_p;
        cfg_par_en_n  = cfg_par_en;
        cfg_par_typ_n = cfg_par_typ;
        par_bad_n     = par_bad;
        stp_bad_n     = stp_bad;
        p_data_n      = P_DATA;
        data_valid_n  = 1'b0;
        par_err_n     = 1'b0;
        stp_err_n     = 1'b0;

        if (state != IDLE) begin
            if (at_s0) samp_n[0] = RX_IN;
            if (at_s1) samp_n[1] = RX_IN;
        end

        case (state)
            IDLE: begin
                edge_cnt_n = 6'd0;
                if (!RX_IN) begin
                    // This edge already counts as sample 0 of the start bit.
                    state_n       = START;
                    edge_cnt_n    = 6'd1;
                    bit_cnt_n     = '0;
                    cfg_p_n       = Prescale;
                    cfg_par_en_n  = PAR_EN;
                    cfg_par_typ_n = PAR_TYP;
                    par_bad_n     = 1'b0;
                    stp_bad_n     = 1'b0;
                end
            end
            START: begin
                if (at_dec && voted) begin
                    state_n    = IDLE;
                    edge_cnt_n = 6'd0;
                end else if (at_end) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (at_dec) shift_n = {voted, shift[DATA_WIDTH-1:1]};
                if (at_end) begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) state_n = cfg_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_dec) par_bad_n = (voted != (cfg_par_typ ^ (^shift)));
                if (at_end) state_n = STOP;
            end
            STOP: begin
                if (at_dec) stp_bad_n = !voted;
                if (at_end) begin
                    state_n = IDLE;
                    if (!par_bad && !stp_bad) begin
                        data_valid_n = 1'b1;
                        p_data_n     = shift;
                    end else begin
                        par_err_n = par_bad;
                        stp_err_n = stp_bad;
                    end
                end
            end
            default: begin
                state_n    = IDLE;
                edge_cnt_n = 6'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed frames plus randomized frames, outcomes
// predicted from frame contents and bit timing alone.
module tb_uart_rx_frame;

    logic       clk;
    logic       rst_n;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic [2:0] fsm_state;

    uart_rx_frame #(.DATA_WIDTH(8)) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .RX_IN      (rx_in),
        .Prescale   (prescale),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .P_DATA     (p_data),
        .Data_Valid (data_valid),
        .Par_Err    (par_err),
        .Stp_Err    (stp_err),
        .fsm_state  (fsm_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // scoreboard: expected and observed outcome pulses
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    logic [2:0] exp_kind_q[$];
    logic [7:0] obs_q[$];
    int         obs_cyc_q[$];
    logic [2:0] obs_kind_q[$];
    logic [7:0] last_good = 8'h00;
    logic [7:0] prev_pdata = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // monitor: records every flag cycle and checks P_DATA only moves with Data_Valid
    always @(negedge clk) begin
        if (rst_n && (data_valid || par_err || stp_err)) begin
            obs_q.push_back(p_data);
            obs_cyc_q.push_back(cyc);
            obs_kind_q.push_back({stp_err, par_err, data_valid});
        end
        if (!rst_n) begin
            prev_pdata = 8'h00;
        end else if (p_data !== prev_pdata) begin
            check("pdata_moved_without_valid", {31'd0, data_valid}, 32'd1);
            prev_pdata = p_data;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int p);
        rx_in = v;
        repeat (p) step();
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) step();
    endtask

    function automatic logic parity_bit(input logic [7:0] d, input logic typ);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        // even: total ones even; odd: total ones odd
        return typ ? logic'(ones % 2 == 0) : logic'(ones % 2 == 1);
    endfunction

    task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                              input logic ptyp, input logic par_flip, input logic stop_v,
                              input logic scramble);
        int         e0;
        int         nbits;
        logic       pbit;
        logic       pe, se;
        int         r;
        pbit     = parity_bit(d, ptyp) ^ par_flip;
        nbits    = pen ? 11 : 10;
        prescale = 6'(p);
        par_en   = pen;
        par_typ  = ptyp;
        e0       = cyc + 1;
        pe = pen && par_flip;
        se = !stop_v;
        if (!pe && !se) last_good = d;
        exp_q.push_back(last_good);
        exp_cyc_q.push_back(e0 + nbits * p - 1);
        exp_kind_q.push_back({se, pe, !pe && !se});
        drive_bit(1'b0, p);
        if (scramble) begin
            r = $urandom_range(0, 2);
            prescale = (r == 0) ? 6'd8 : (r == 1) ? 6'd16 : 6'd32;
            par_en   = 1'($urandom);
            par_typ  = 1'($urandom);
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(stop_v, p);
    endtask

    task automatic check_events(input string tag);
        int n;
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_cycle"}, 32'(obs_cyc_q[i]), 32'(exp_cyc_q[i]));
            check({tag, "_kind"}, {29'd0, obs_kind_q[i]}, {29'd0, exp_kind_q[i]});
            check({tag, "_pdata"}, {24'd0, obs_q[i]}, {24'd0, exp_q[i]});
        end
        obs_q.delete(); obs_cyc_q.delete(); obs_kind_q.delete();
        exp_q.delete(); exp_cyc_q.delete(); exp_kind_q.delete();
    endtask

    initial begin
        int c;
        int r;
        int p;
        rst_n    = 1'b0;
        rx_in    = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b1;
        par_typ  = 1'b0;
        repeat (3) step();
        check("reset_pdata", {24'd0, p_data}, 32'h0);
        check("reset_valid", {31'd0, data_valid}, 32'd0);
        check("reset_par_err", {31'd0, par_err}, 32'd0);
        check("reset_stp_err", {31'd0, stp_err}, 32'd0);
        check("reset_state", {29'd0, fsm_state}, 32'd0);
        rst_n = 1'b1;
        idle(4);

        // single good frame, P=8 even parity
        send_frame(8'hAA, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check_events("single_aa");

        // back-to-back frames, no idle gap
        send_frame(8'hAA, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h05, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h77, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check_events("b2b");

        // parity error then corrected parity
        send_frame(8'h02, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(4);
        send_frame(8'h02, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check_events("parity");

        // stop error followed directly by a good frame
        send_frame(8'hBB, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hCC, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check_events("stop_err");

        // glitch abort at P=16 without parity, then a good frame
        prescale = 6'd16;
        par_en   = 1'b0;
        c = cyc;
        rx_in = 1'b0;
        repeat (2) step();
        rx_in = 1'b1;
        while (cyc < c + 8) step();
        check("glitch_state_e7", {29'd0, fsm_state}, 32'd1);
        step();
        check("glitch_state_e8", {29'd0, fsm_state}, 32'd0);
        idle(20);
        send_frame(8'hDD, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check_events("glitch_dd");

        // reset pulse during the data bits discards the frame
        prescale = 6'd8;
        par_en   = 1'b1;
        par_typ  = 1'b0;
        drive_bit(1'b0, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 4);
        rst_n = 1'b0;
        step();
        check("midreset_pdata", {24'd0, p_data}, 32'h0);
        check("midreset_valid", {31'd0, data_valid}, 32'd0);
        check("midreset_errs", {30'd0, par_err, stp_err}, 32'd0);
        check("midreset_state", {29'd0, fsm_state}, 32'd0);
        rst_n = 1'b1;
        last_good = 8'h00;
        idle(120);
        check_events("midreset_quiet");
        send_frame(8'h05, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check_events("after_reset");

        // randomized frames with mid-frame config churn
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 2);
            p = (r == 0) ? 8 : (r == 1) ? 16 : 32;
            send_frame(8'($urandom), p, 1'($urandom), 1'($urandom),
                       logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 4) != 0), 1'b1);
            idle($urandom_range(0, 3) * p);
        end
        idle(8);
        check_events("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Oversampling UART frame receiver for the system's serial input path. Deserialises one start bit, DATA_WIDTH data bits (LSB first), an optional parity bit and one stop bit from RX_IN, sampled at Prescale times the bit rate. Feeds received bytes, with valid and error flags, to the system controller's command parser. The parser consumes command bytes 0xAA, 0xBB, 0xCC and 0xDD and their operands.

## Interface
- DATA_WIDTH, 8, payload bits per frame
- CLK  in  1  oversampling clock (UART clock domain); all logic on rising edge
- RST_N  in  1  reset, synchronous, active-low
- RX_IN  in  1  serial line, idle high; already synchronous to CLK
- Prescale  in  6  oversampling ratio; legal values 8, 16, 32 only
- PAR_EN  in  1  1 = parity bit present
- PAR_TYP  in  1  0 = even parity, 1 = odd parity
- P_DATA  out  DATA_WIDTH  last good byte; changes only when Data_Valid is issued
- Data_Valid  out  1  one-cycle pulse: P_DATA updated, frame error-free
- Par_Err  out  1  one-cycle pulse: parity mismatch in the frame just ended
- Stp_Err  out  1  one-cycle pulse: stop bit sampled low

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: an edge sampling RX_IN=0 is edge E0 of the start bit.
  - At E0, latch Prescale (P), PAR_EN and PAR_TYP for the whole frame.
  - Clear edge_cnt to the state after sample 0 (edge_cnt=1).
  - Go to START.
- Each bit lasts P CLK cycles; edge_cnt runs 0..P-1 within each bit.
- Bit value is the majority of RX_IN at edge_cnt = P/2-2, P/2-1, P/2. The decision is taken at edge_cnt=P/2.
- START:
  - If the decided value is 1, it is a glitch: go to IDLE at the decision edge with no outputs.
  - Otherwise go to DATA after edge_cnt=P-1.
- DATA: shift each decided bit into a shift register LSB first. Leave after DATA_WIDTH bits, to PARITY if PAR_EN=1, else to STOP.
- PARITY: compute the expected bit from the shift register.
  - Even: XOR of data bits.
  - Odd: inverted XOR of data bits.
  - Record a mismatch flag.
- STOP:
  - A decided 0 records a stop error.
  - At edge_cnt=P-1 the outcome edge fires and the FSM returns to IDLE.
- Outcome edge, exactly one of:
  - No errors: Data_Valid=1 and P_DATA loaded from the shift register.
  - Otherwise: Par_Err and/or Stp_Err=1 for that cycle. Data_Valid stays 0 and P_DATA holds its old value. Both error flags may pulse together.
- Input changes to Prescale, PAR_EN or PAR_TYP mid-frame do not affect the current frame.
- Reset (RST_N=0 at any edge, including mid-frame): IDLE, edge_cnt=0, bit counter=0, shift register=0, P_DATA=0, Data_Valid=0, Par_Err=0, Stp_Err=0. The partial frame is discarded with no flags.

## Timing
- N = 11 bits with parity, 10 bits without (DATA_WIDTH=8).
- The outcome edge is E(N·P−1). Flags are registered and high for exactly one cycle after that edge, low again after E(N·P).
- Back-to-back frames: IDLE is entered at E(N·P−1). A start bit beginning on the next edge is detected at E(N·P) as the new frame's E0, with zero dead cycles. Consecutive Data_Valid pulses are exactly N·P cycles apart.
- Glitch abort: the return to IDLE happens at E(P/2). A low pulse no longer than P/2−2 cycles starting at E0 always aborts.
- The outputs are stable between pulses. P_DATA is stable from the Data_Valid edge until the next good frame.
- There is no backpressure: the consumer must take P_DATA on the Data_Valid cycle.

## Test plan
- P=8, PAR_EN=1, PAR_TYP=0, frame 0xAA with parity bit 0 -> one Data_Valid at E87, P_DATA=0xAA, no error flags.
- Same configuration, three back-to-back frames 0xAA, 0x05, 0x77 (all parity 0) -> Data_Valid at E87, E175, E263; P_DATA=0xAA, then 0x05, then 0x77; no idle gap needed.
- P=8, even parity, frame 0x02 with parity bit 0 -> Par_Err pulse at E87, no Data_Valid, P_DATA keeps its previous value. Repeat with parity bit 1 -> Data_Valid, P_DATA=0x02.
- P=8, frame 0xBB with correct parity and stop bit driven 0 -> Stp_Err pulse at E87, no Data_Valid. A following good frame 0xCC decodes normally.
- P=16, PAR_EN=0: first a 2-cycle low glitch on RX_IN -> no outputs, FSM in IDLE by E8. Then frame 0xDD -> Data_Valid at E159, P_DATA=0xDD.
- P=8: assert RST_N=0 for one edge during the data bits of 0xAA -> all outputs 0 and no pulses for that frame. A subsequent 0x05 frame -> Data_Valid, P_DATA=0x05.
